lcd_seq: RTL and testbench

Character-LCD command/text sequencer feeding the LCD write stage, which generates RS/E/D pin timing for one byte per transfer. Runs the HD44780 power-up initialisation, then redraws a 32-byte on-chip character buffer on request. Emits one byte per valid/ready transfer, tagged with RS (0 = command, 1 = data). Inter-byte execution delays are owned by the write stage, except the extra clear-display delay, which is owned here.

---
 rtl/lcd_seq.sv | 258 +++++++++++++++++++++++++
 tb/tb_lcd_seq.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_seq.sv
// lcd_seq: character-LCD command/text sequencer.
// Runs the HD44780 power-up initialisation, then redraws a 32-byte
// character buffer on request, one byte per valid/ready transfer.
// Build option: define LCD_SEQ_TWO_LINE_EN for the two-line display
// (function set 0x38, 34-byte refresh). Without it the display is driven
// as one line (function set 0x30, 17-byte refresh, line 2 never sent).
//
// Handshake: a byte is offered while wr_valid is high; it is transferred on
// the clock edge where wr_valid && wr_ready. While wr_valid && !wr_ready,
// wr_valid, wr_rs and wr_data hold. After every transfer wr_valid is low for
// at least one cycle before the next byte is offered.
module lcd_seq #(
    parameter int POWERUP_CYC = 4_000_000,
    parameter int CLEAR_CYC   = 164_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       buf_we,
    input  logic [4:0] buf_addr,
    input  logic [7:0] buf_data,
    input  logic       refresh,
    output logic       wr_valid,
    input  logic       wr_ready,
    output logic       wr_rs,
    output logic [7:0] wr_data,
    output logic       busy,
    output logic       init_done,
    output logic [2:0] o_dbg_state
);

`ifdef LCD_SEQ_TWO_LINE_EN
    localparam logic [7:0] FUNC_SET = 8'h38;
    localparam int         REF_LEN  = 34;
`else
    localparam logic [7:0] FUNC_SET = 8'h30;
    localparam int         REF_LEN  = 17;
`endif

    localparam logic [5:0] REF_LAST = 6'(REF_LEN - 1);

    // One counter serves both the power-up wait and the clear-display wait.
    localparam int CNT_MAX = (POWERUP_CYC > CLEAR_CYC) ? POWERUP_CYC : CLEAR_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] PWR_LAST = CNT_W'(POWERUP_CYC - 1);
    localparam logic [CNT_W-1:0] CLR_LAST = CNT_W'(CLEAR_CYC - 1);

    typedef enum logic [2:0] {
        ST_PWRUP    = 3'd0,
        ST_INIT     = 3'd1,
        ST_CLR_WAIT = 3'd2,
        ST_REFRESH  = 3'd3,
        ST_IDLE     = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    // Index of the byte currently offered, or the next one to load.
    // INIT uses 0..3, REFRESH uses 0..REF_LAST.
    logic [5:0]       r_idx;
    logic             r_valid;
    logic             r_rs;
    logic [7:0]       r_data;
    logic             r_init_done;
    logic             r_pend;
    logic [7:0]       r_buf [32];

    logic             w_xfer;
    logic             w_ref_last;
    logic             w_load;
    logic             w_load_rs;
    logic             w_load_rd;
    logic [4:0]       w_load_addr;
    logic [7:0]       w_load_cmd;
    logic [5:0]       w_idx_next;
    logic             w_start;

    assign w_xfer     = r_valid && wr_ready;
    assign w_ref_last = (r_idx == REF_LAST);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_PWRUP;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_PWRUP: begin
                if (r_cnt == PWR_LAST) begin
                    w_next = ST_INIT;
                end
            end
            ST_INIT: begin
                if (w_xfer && r_idx == 6'd2) begin
                    w_next = ST_CLR_WAIT;
                end else if (w_xfer && r_idx == 6'd3) begin
                    w_next = ST_REFRESH;
                end
            end
            ST_CLR_WAIT: begin
                if (r_cnt == CLR_LAST) begin
                    w_next = ST_INIT;
                end
            end
            ST_REFRESH: begin
                // A request pending (or arriving now) restarts the redraw.
                if (w_xfer && w_ref_last && !(r_pend || refresh)) begin
                    w_next = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (refresh) begin
                    w_next = ST_REFRESH;
                end
            end
            default: w_next = ST_PWRUP;
        endcase
    end

    // Output logic: when to load a new byte, what it is, index stepping.
    always_comb begin
        w_load      = 1'b0;
        w_load_rs   = 1'b0;
        w_load_rd   = 1'b0;
        w_load_addr = 5'd0;
        w_load_cmd  = 8'h00;
        w_idx_next  = r_idx;
        w_start     = 1'b0;

        case (r_state)
            ST_PWRUP: begin
                // First command is offered directly as the wait expires.
                w_load = (r_cnt == PWR_LAST);
            end
            ST_CLR_WAIT: begin
                w_load = (r_cnt == CLR_LAST);
            end
            ST_INIT: begin
                if (!r_valid) begin
                    w_load = 1'b1;
                end else if (w_xfer) begin
                    w_idx_next = (r_idx == 6'd3) ? 6'd0 : r_idx + 6'd1;
                    w_start    = (r_idx == 6'd3);
                end
            end
            ST_REFRESH: begin
                if (!r_valid) begin
                    w_load = 1'b1;
                end else if (w_xfer) begin
                    w_idx_next = w_ref_last ? 6'd0 : r_idx + 6'd1;
                    w_start    = w_ref_last && (r_pend || refresh);
                end
            end
            ST_IDLE: begin
                // 0x80 goes out on the same edge busy rises.
                w_load  = refresh;
                w_start = refresh;
            end
            default: begin
                w_load = 1'b0;
            end
        endcase

        // Byte decode from the phase and the index.
        if (r_state == ST_REFRESH || r_state == ST_IDLE) begin
            if (r_idx == 6'd0) begin
                w_load_cmd = 8'h80;
            end else if (r_idx <= 6'd16) begin
                w_load_rs   = 1'b1;
                w_load_rd   = 1'b1;
                w_load_addr = r_idx[4:0] - 5'd1;
`ifdef LCD_SEQ_TWO_LINE_EN
            end else if (r_idx == 6'd17) begin
                w_load_cmd = 8'hC0;
            end else begin
                // Indices 18..33 wrap modulo 32 onto buffer 16..31.
                w_load_rs   = 1'b1;
                w_load_rd   = 1'b1;
                w_load_addr = r_idx[4:0] - 5'd2;
`endif
            end
        end else begin
            case (r_idx[1:0])
                2'd0:    w_load_cmd = FUNC_SET;
                2'd1:    w_load_cmd = 8'h0C;
                2'd2:    w_load_cmd = 8'h01;
                default: w_load_cmd = 8'h06;
            endcase
        end
    end

    // Datapath: wait counter, byte index, offered byte, sticky flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_idx       <= 6'd0;
            r_valid     <= 1'b0;
            r_rs        <= 1'b0;
            r_data      <= 8'h00;
            r_init_done <= 1'b0;
            r_pend      <= 1'b0;
        end else begin
            r_idx <= w_idx_next;

            if (r_state != w_next) begin
                r_cnt <= '0;
            end else if (r_state == ST_PWRUP || r_state == ST_CLR_WAIT) begin
                r_cnt <= r_cnt + 1'b1;
            end

            // Buffer is read here with its pre-edge contents, so a write
            // landing on the same edge is not seen by this byte.
            if (w_load) begin
                r_valid <= 1'b1;
                r_rs    <= w_load_rs;
                r_data  <= w_load_rd ? r_buf[w_load_addr] : w_load_cmd;
            end else if (w_xfer) begin
                r_valid <= 1'b0;
            end

            if (r_state == ST_INIT && w_xfer && r_idx == 6'd3) begin
                r_init_done <= 1'b1;
            end

            // One-deep pending request; any redraw start consumes it.
            if (w_start) begin
                r_pend <= 1'b0;
            end else if (refresh && r_state != ST_IDLE) begin
                r_pend <= 1'b1;
            end
        end
    end

    // Character buffer: always writable, cleared to spaces on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                r_buf[i] <= 8'h20;
            end
        end else if (buf_we) begin
            r_buf[buf_addr] <= buf_data;
        end
    end

    assign wr_valid    = r_valid;
    assign wr_rs       = r_rs;
    assign wr_data     = r_data;
    assign busy        = (r_state != ST_IDLE);
    assign init_done   = r_init_done;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_lcd_seq.sv
// tb_lcd_seq: bench for lcd_seq with short power-up/clear waits.
// Follows the display mode selected by LCD_SEQ_TWO_LINE_EN.
module tb_lcd_seq;

    localparam int PWR = 10;
    localparam int CLR = 5;
`ifdef LCD_SEQ_TWO_LINE_EN
    localparam bit TWO_LINE = 1'b1;
`else
    localparam bit TWO_LINE = 1'b0;
`endif
    localparam logic [7:0] FSET  = TWO_LINE ? 8'h38 : 8'h30;
    localparam int         REF_N = TWO_LINE ? 34 : 17;

    typedef struct {
        logic [4:0] addr;
        logic [7:0] data;
        int         exp_cnt;
        int         exp_pos;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       buf_we = 1'b0;
    logic [4:0] buf_addr = 5'd0;
    logic [7:0] buf_data = 8'h00;
    logic       refresh = 1'b0;
    logic       wr_valid;
    logic       wr_ready = 1'b1;
    logic       wr_rs;
    logic [7:0] wr_data;
    logic       busy;
    logic       init_done;
    logic [2:0] dbg_state;

    lcd_seq #(
        .POWERUP_CYC(PWR),
        .CLEAR_CYC  (CLR)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .buf_we     (buf_we),
        .buf_addr   (buf_addr),
        .buf_data   (buf_data),
        .refresh    (refresh),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_rs      (wr_rs),
        .wr_data    (wr_data),
        .busy       (busy),
        .init_done  (init_done),
        .o_dbg_state(dbg_state)
    );

    // Clock and watchdog.
    always #5 clk = ~clk;

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
        $fatal(1, "watchdog");
    end

    // Scoreboard and reference model state.
    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc = 0;
    int         due = -1;
    int         n_busy_fall = 0;
    logic [7:0] m_buf [32];
    int         slot_q[$];      // <256: command byte, >=256: buffer index+256
    int         cur_slot = -1;
    bit         m_busy = 1'b1;
    bit         m_init_done = 1'b0;
    bit         m_pend = 1'b0;
    logic [8:0] sent_q[$];      // {rs, data} of every accepted byte
    int         acc_cyc[$];     // cycle of every accept
    logic [8:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic void push_refresh();
        slot_q.push_back(32'h80);
        for (int i = 0; i < 16; i++) slot_q.push_back(256 + i);
        if (TWO_LINE) begin
            slot_q.push_back(32'hC0);
            for (int i = 16; i < 32; i++) slot_q.push_back(256 + i);
        end
    endfunction

    function automatic int count_of(input logic [8:0] v);
        int n = 0;
        foreach (sent_q[i]) if (sent_q[i] == v) n++;
        return n;
    endfunction

    function automatic int pos_of(input logic [8:0] v);
        foreach (sent_q[i]) if (sent_q[i] == v) return i;
        return -1;
    endfunction

    // Hold reset for n edges, check reset outputs, restart the model.
    task automatic do_reset(input int n);
        rst = 1'b1;
        buf_we = 1'b0;
        refresh = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
        check("rst_valid", 32'(wr_valid), 32'd0);
        check("rst_rs", 32'(wr_rs), 32'd0);
        check("rst_data", 32'(wr_data), 32'h00);
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_init_done", 32'(init_done), 32'd0);
        for (int i = 0; i < 32; i++) m_buf[i] = 8'h20;
        slot_q.delete();
        slot_q.push_back(32'(FSET));
        slot_q.push_back(32'h0C);
        slot_q.push_back(32'h01);
        slot_q.push_back(32'h06);
        cur_slot = -1;
        m_busy = 1'b1;
        m_init_done = 1'b0;
        m_pend = 1'b0;
        rst = 1'b0;
        cyc = 0;
        due = PWR;
    endtask

    // Advance one clock with rst low, updating the model and checking outputs.
    task automatic step();
        logic       pv, pr, prs, pb;
        logic [7:0] pd;
        logic [7:0] snap [32];
        bit         xfer, pulse, rose;
        logic       e_rs;
        logic [7:0] e_data;
        pv = wr_valid;
        pr = wr_ready;
        prs = wr_rs;
        pd = wr_data;
        pb = busy;
        xfer = pv && pr;
        pulse = refresh;
        snap = m_buf;
        if (buf_we) m_buf[buf_addr] = buf_data;
        if (xfer) begin
            sent_q.push_back({prs, pd});
            acc_cyc.push_back(cyc);
            if (cur_slot == 32'h06) begin
                m_init_done = 1'b1;
                push_refresh();
                m_pend = 1'b0;
                due = cyc + 2;
            end else if (slot_q.size() == 0) begin
                if (m_pend || pulse) begin
                    push_refresh();
                    m_pend = 1'b0;
                    due = cyc + 2;
                end else begin
                    m_busy = 1'b0;
                    due = -1;
                end
            end else begin
                due = (cur_slot == 32'h01) ? cyc + 1 + CLR : cyc + 2;
                if (pulse) m_pend = 1'b1;
            end
        end else if (pulse) begin
            if (!m_busy) begin
                push_refresh();
                m_busy = 1'b1;
                due = cyc + 1;
            end else begin
                m_pend = 1'b1;
            end
        end

        @(posedge clk);
        #1;
        cyc++;

        rose = wr_valid && !pv;
        check("valid_timing", 32'(rose), 32'(cyc == due));
        if (xfer) check("drop_after_accept", 32'(wr_valid), 32'd0);
        if (rose) begin
            check("byte_expected", 32'(slot_q.size() != 0), 32'd1);
            if (slot_q.size() != 0) begin
                cur_slot = slot_q.pop_front();
                e_rs = (cur_slot >= 256);
                e_data = (cur_slot >= 256) ? snap[cur_slot - 256] : 8'(cur_slot);
                check("byte_rs", 32'(wr_rs), 32'(e_rs));
                check("byte_data", 32'(wr_data), 32'(e_data));
            end
        end
        if (pv && !pr) begin
            check("hold_stable", 32'({wr_valid, wr_rs, wr_data}), 32'({1'b1, prs, pd}));
        end
        check("busy", 32'(busy), 32'(m_busy));
        check("init_done", 32'(init_done), 32'(m_init_done));
        if (pb && !busy) n_busy_fall++;
    endtask

    task automatic run_until_idle(input int budget);
        int k = 0;
        while ((busy || m_busy) && k < budget) begin
            step();
            k++;
        end
        check("idle_reached", 32'(busy), 32'd0);
    endtask

    task automatic pulse_refresh();
        refresh = 1'b1;
        step();
        refresh = 1'b0;
    endtask

    initial begin
        vec_t vecs [3];
        int   k;
        vecs[0] = '{addr: 5'd0,  data: 8'h48, exp_cnt: 1, exp_pos: 1};
        vecs[1] = '{addr: 5'd1,  data: 8'h49, exp_cnt: 1, exp_pos: 2};
        vecs[2] = '{addr: 5'd31, data: 8'h5A, exp_cnt: int'(TWO_LINE),
                    exp_pos: TWO_LINE ? 33 : -1};

        // Power-up sequence with wr_ready high.
        do_reset(3);
        wr_ready = 1'b1;
        sent_q.delete();
        acc_cyc.delete();
        run_until_idle(400);
        exp_q.delete();
        exp_q.push_back({1'b0, FSET});
        exp_q.push_back({1'b0, 8'h0C});
        exp_q.push_back({1'b0, 8'h01});
        exp_q.push_back({1'b0, 8'h06});
        exp_q.push_back({1'b0, 8'h80});
        for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, 8'h20});
        if (TWO_LINE) begin
            exp_q.push_back({1'b0, 8'hC0});
            for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, 8'h20});
        end
        check("init_len", 32'(sent_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < sent_q.size(); i++) begin
            check("init_stream", 32'(sent_q[i]), 32'(exp_q[i]));
        end
        if (acc_cyc.size() >= 4 + REF_N) begin
            check("first_byte_cycle", 32'(acc_cyc[0]), 32'(PWR));
            check("clear_gap", 32'(acc_cyc[3] - acc_cyc[2]), 32'(CLR + 1));
            check("refresh_span", 32'(acc_cyc[3 + REF_N] - acc_cyc[4]), 32'(2 * (REF_N - 1)));
        end else begin
            check("accept_count", 32'(acc_cyc.size()), 32'(4 + REF_N));
        end

        // Table-driven buffer writes in IDLE, then a redraw.
        for (int i = 0; i < 3; i++) begin
            buf_we = 1'b1;
            buf_addr = vecs[i].addr;
            buf_data = vecs[i].data;
            step();
        end
        buf_we = 1'b0;
        sent_q.delete();
        pulse_refresh();
        run_until_idle(200);
        check("hi_len", 32'(sent_q.size()), 32'(REF_N));
        check("hi_c0_count", 32'(count_of({1'b0, 8'hC0})), 32'(int'(TWO_LINE)));
        for (int i = 0; i < 3; i++) begin
            check("vec_count", 32'(count_of({1'b1, vecs[i].data})), 32'(vecs[i].exp_cnt));
            check("vec_pos", 32'(pos_of({1'b1, vecs[i].data})), 32'(vecs[i].exp_pos));
        end

        // Three refresh pulses during a redraw merge into one more redraw.
        sent_q.delete();
        n_busy_fall = 0;
        pulse_refresh();
        repeat (4) step();
        for (int i = 0; i < 3; i++) begin
            pulse_refresh();
            repeat (5) step();
        end
        run_until_idle(300);
        check("pend_redraws", 32'(count_of({1'b0, 8'h80})), 32'd2);
        check("pend_len", 32'(sent_q.size()), 32'(2 * REF_N));
        check("pend_busy_falls", 32'(n_busy_fall), 32'd1);

        // Reset for one cycle at byte 10 of a redraw.
        buf_we = 1'b1;
        buf_addr = 5'd3;
        buf_data = 8'h51;
        step();
        buf_we = 1'b0;
        sent_q.delete();
        pulse_refresh();
        k = 0;
        while (sent_q.size() < 10 && k < 100) begin
            step();
            k++;
        end
        check("reached_byte10", 32'(sent_q.size()), 32'd10);
        do_reset(1);
        sent_q.delete();
        run_until_idle(400);
        check("rerun_len", 32'(sent_q.size()), 32'(4 + REF_N));
        check("rerun_no_q", 32'(count_of({1'b1, 8'h51})), 32'd0);
        check("rerun_spaces", 32'(count_of({1'b1, 8'h20})), 32'(TWO_LINE ? 32 : 16));

        // Backpressure on 0x0C for 7 cycles.
        do_reset(1);
        wr_ready = 1'b1;
        sent_q.delete();
        k = 0;
        while (!(wr_valid && wr_data == 8'h0C) && k < 100) begin
            step();
            k++;
        end
        check("bp_offered", 32'({wr_valid, wr_data}), 32'({1'b1, 8'h0C}));
        wr_ready = 1'b0;
        repeat (7) step();
        check("bp_still_offered", 32'({wr_valid, wr_rs, wr_data}), 32'({1'b1, 1'b0, 8'h0C}));
        check("bp_none_sent", 32'(count_of({1'b0, 8'h0C})), 32'd0);
        wr_ready = 1'b1;
        step();
        check("bp_one_sent", 32'(count_of({1'b0, 8'h0C})), 32'd1);
        run_until_idle(400);
        check("bp_total_0c", 32'(count_of({1'b0, 8'h0C})), 32'd1);

        // Randomized traffic from reset against the model.
        do_reset(2);
        for (int i = 0; i < 1500; i++) begin
            wr_ready = ($urandom_range(0, 9) < 7);
            buf_we = ($urandom_range(0, 3) == 0);
            buf_addr = 5'($urandom_range(0, 31));
            buf_data = 8'($urandom_range(0, 255));
            refresh = ($urandom_range(0, 49) == 0);
            step();
        end
        wr_ready = 1'b1;
        buf_we = 1'b0;
        refresh = 1'b0;
        run_until_idle(400);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
